cnn_pixel_streamer: RTL



---
 rtl/cnn_pixel_streamer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cnn_pixel_streamer.sv
// Pixel streamer: holds one frame in a single-port BRAM and streams it
// to the accelerator one pixel per ready cycle, padding afterwards.
module cnn_pixel_streamer #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0,
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW   = $clog2(NPIX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_we,
  input  logic [AW-1:0]         load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  go,
  output logic                  busy,
  output logic                  acc_start,
  input  logic                  acc_ready,
  output logic [DATA_WIDTH-1:0] pixel_data,
  input  logic                  acc_done,
  output logic                  all_done,
  output logic [AW:0]           pix_count,
  output logic                  err_early
);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    START,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  state_t state;
  state_t state_nx;

  logic [AW-1:0]         idx;
  logic [AW-1:0]         idx_nx;
  logic [AW:0]           cnt_nx;
  logic                  err_nx;
  logic [DATA_WIDTH-1:0] pad_q;
  logic [DATA_WIDTH-1:0] pad_nx;

  logic [DATA_WIDTH-1:0] mem [NPIX];
  logic [DATA_WIDTH-1:0] dout;
  logic [AW-1:0]         ram_addr;
  logic                  ram_we;

  logic streaming;
  logic consume;
  logic last;

  assign streaming = (state == START) || (state == STREAM);
  assign consume   = streaming && acc_ready;
  assign last      = (idx == LAST);

  // Host writes are only honoured while the frame is not being read.
  assign ram_we = load_we && (state == IDLE);

  always_comb begin
    ram_addr = idx;
    unique case (state)
      IDLE:          ram_addr = load_addr;
      PRIME:         ram_addr = '0;
      START, STREAM: ram_addr = idx + AW'(acc_ready);
      default:       ram_addr = idx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= load_data;
    end
    dout <= mem[ram_addr];
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = pix_count;
    err_nx   = err_early;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_nx = PRIME;
          idx_nx   = '0;
          cnt_nx   = '0;
          err_nx   = 1'b0;
        end
      end
      PRIME: state_nx = START;
      START, STREAM: begin
        state_nx = STREAM;
        if (consume) begin
          idx_nx = idx + AW'(1);
          cnt_nx = pix_count + (AW+1)'(1);
          if (last) begin
            state_nx = DRAIN;
          end
        end
        // A done arriving with the final pixel is not early.
        if (acc_done) begin
          state_nx = DONE;
          if (!(consume && last)) begin
            err_nx = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (acc_done) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign pad_nx = (state_nx == DRAIN) ? PAD_VALUE : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      pix_count <= '0;
      err_early <= 1'b0;
      pad_q     <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      pix_count <= cnt_nx;
      err_early <= err_nx;
      pad_q     <= pad_nx;
    end
  end

  assign busy       = (state != IDLE);
  assign acc_start  = (state == START);
  assign all_done   = (state == DONE);
  assign pixel_data = streaming ? dout : pad_q;

endmodule
